// File: rtl/misc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : misc_pkg
// Brief    : Shared constants and types for the Misc result path.
// Revision : 1.0 - initial release
// ============================================================================
package misc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage
`default_nettype wire

// File: rtl/misc_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : misc_fifo_mem
// Brief    : DEPTH x 2*WIDTH register array, one write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
module misc_fifo_mem
  import misc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [2*WIDTH-1:0]   wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [2*WIDTH-1:0]   rdata_o
);

  // No reset on storage: the consumer masks the read data while empty.
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/misc_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : misc_out_fifo
// Brief    : Output FIFO for XOUT1/XOUT2 pairs with head sum and drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module misc_out_fifo
  import misc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         XOUT1,
  input  logic [WIDTH-1:0]         XOUT2,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT_A,
  output logic [WIDTH-1:0]         OUT_B,
  output logic [WIDTH:0]           OUT_SUM,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [7:0]               DROPS
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [7:0]         drops_q,  drops_d;
  logic               push, pop;
  logic [2*WIDTH-1:0] head;

  // Flags come only from registered occupancy, so a same-cycle pop never
  // opens a full FIFO and nothing bypasses storage.
  assign IN_READY  = (count_q != FULL_CNT);
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  misc_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({XOUT2, XOUT1}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (IN_VALID && !IN_READY && (drops_q != 8'hFF)) drops_d = drops_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  assign OUT_A   = OUT_VALID ? head[WIDTH-1:0]       : '0;
  assign OUT_B   = OUT_VALID ? head[2*WIDTH-1:WIDTH] : '0;
  assign OUT_SUM = {1'b0, OUT_A} + {1'b0, OUT_B};
  assign COUNT   = count_q;
  assign DROPS   = drops_q;

endmodule
`default_nettype wire

// File: tb/tb_misc_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_misc_out_fifo
// Brief    : Directed, table-driven self-checking bench for misc_out_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_misc_out_fifo;
  import misc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [7:0] XOUT1, XOUT2, OUT_A, OUT_B, DROPS;
  logic [8:0] OUT_SUM;
  logic [2:0] COUNT;

  int checks = 0;
  int errors = 0;

  misc_out_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .XOUT1     (XOUT1),
    .XOUT2     (XOUT2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_A     (OUT_A),
    .OUT_B     (OUT_B),
    .OUT_SUM   (OUT_SUM),
    .COUNT     (COUNT),
    .DROPS     (DROPS)
  );

  always #5 CLK = ~CLK;

  // {valid, in_ready, a, b, sum, count, drops}
  typedef logic [37:0] obs_t;

  typedef struct {
    logic       iv;
    logic [7:0] x1;
    logic [7:0] x2;
    logic       ordy;
    logic       e_valid;
    logic       e_irdy;
    logic [7:0] e_a;
    logic [7:0] e_b;
    sum_t       e_sum;
    logic [2:0] e_cnt;
    logic [7:0] e_drops;
  } vec_t;

  function automatic obs_t pack(input logic v, input logic r, input logic [7:0] a,
                                input logic [7:0] b, input logic [8:0] s,
                                input logic [2:0] c, input logic [7:0] d);
    return {v, r, a, b, s, c, d};
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = pack(OUT_VALID, IN_READY, OUT_A, OUT_B, OUT_SUM, COUNT, DROPS);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b rdy=%b a=%h b=%h sum=%h cnt=%0d drops=%0d, want v=%b rdy=%b a=%h b=%h sum=%h cnt=%0d drops=%0d",
               name, act[37], act[36], act[35:28], act[27:20], act[19:11], act[10:8], act[7:0],
               exp[37], exp[36], exp[35:28], exp[27:20], exp[19:11], exp[10:8], exp[7:0]);
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] x1, input logic [7:0] x2, input logic ordy);
    IN_VALID = iv; XOUT1 = x1; XOUT2 = x2; OUT_READY = ordy;
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 8'h10, 8'h20, 0, 1, 1, 8'h10, 8'h20, 9'h030, 3'd1, 8'd0};
    vecs[1]  = '{1, 8'hFF, 8'hFF, 1, 1, 1, 8'hFF, 8'hFF, 9'h1FE, 3'd1, 8'd0};
    vecs[2]  = '{0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00, 9'h000, 3'd0, 8'd0};
    vecs[3]  = '{1, 8'h01, 8'h02, 0, 1, 1, 8'h01, 8'h02, 9'h003, 3'd1, 8'd0};
    vecs[4]  = '{1, 8'h03, 8'h04, 0, 1, 1, 8'h01, 8'h02, 9'h003, 3'd2, 8'd0};
    vecs[5]  = '{1, 8'h05, 8'h06, 0, 1, 1, 8'h01, 8'h02, 9'h003, 3'd3, 8'd0};
    vecs[6]  = '{1, 8'h07, 8'h08, 0, 1, 0, 8'h01, 8'h02, 9'h003, 3'd4, 8'd0};
    vecs[7]  = '{1, 8'h09, 8'h0A, 0, 1, 0, 8'h01, 8'h02, 9'h003, 3'd4, 8'd1};
    vecs[8]  = '{1, 8'h0B, 8'h0C, 1, 1, 1, 8'h03, 8'h04, 9'h007, 3'd3, 8'd2};
    vecs[9]  = '{0, 8'h00, 8'h00, 1, 1, 1, 8'h05, 8'h06, 9'h00B, 3'd2, 8'd2};
    vecs[10] = '{0, 8'h00, 8'h00, 1, 1, 1, 8'h07, 8'h08, 9'h00F, 3'd1, 8'd2};
    vecs[11] = '{0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00, 9'h000, 3'd0, 8'd2};
    vecs[12] = '{1, 8'h0A, 8'h0B, 0, 1, 1, 8'h0A, 8'h0B, 9'h015, 3'd1, 8'd2};
    vecs[13] = '{1, 8'h0C, 8'h0D, 1, 1, 1, 8'h0C, 8'h0D, 9'h019, 3'd1, 8'd2};
    vecs[14] = '{0, 8'h00, 8'h00, 0, 1, 1, 8'h0C, 8'h0D, 9'h019, 3'd1, 8'd2};

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; XOUT1 = '0; XOUT2 = '0;
    #2;
    check("reset_state", pack(0, 1, 8'h00, 8'h00, 9'h000, 3'd0, 8'd0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].iv, vecs[i].x1, vecs[i].x2, vecs[i].ordy);
      check($sformatf("vec%0d", i), pack(vecs[i].e_valid, vecs[i].e_irdy, vecs[i].e_a, vecs[i].e_b,
                                         vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_drops));
    end

    // Fill behind the held 0C/0D entry, then hammer a full FIFO.
    cycle(1, 8'h21, 8'h22, 0);
    cycle(1, 8'h23, 8'h24, 0);
    cycle(1, 8'h25, 8'h26, 0);
    check("refill_full", pack(1, 0, 8'h0C, 8'h0D, 9'h019, 3'd4, 8'd2));
    for (int i = 0; i < 100; i++) cycle(1, 8'h77, 8'h77, 0);
    check("drops_102", pack(1, 0, 8'h0C, 8'h0D, 9'h019, 3'd4, 8'd102));
    for (int i = 0; i < 200; i++) cycle(1, 8'h77, 8'h77, 0);
    check("drops_sat", pack(1, 0, 8'h0C, 8'h0D, 9'h019, 3'd4, 8'd255));
    for (int i = 0; i < 5; i++) cycle(1, 8'h77, 8'h77, 0);
    check("drops_hold", pack(1, 0, 8'h0C, 8'h0D, 9'h019, 3'd4, 8'd255));

    // Pop in order, leaving three entries.
    cycle(0, 8'h00, 8'h00, 1);
    check("pop_to_3", pack(1, 1, 8'h21, 8'h22, 9'h043, 3'd3, 8'd255));

    // Reset between edges must clear everything before the next edge.
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    #2 RST = 1'b1;
    #1 check("async_reset", pack(0, 1, 8'h00, 8'h00, 9'h000, 3'd0, 8'd0));
    #1 RST = 1'b0;
    cycle(1, 8'h55, 8'h66, 0);
    check("push_after_rst", pack(1, 1, 8'h55, 8'h66, 9'h0BB, 3'd1, 8'd0));
    cycle(0, 8'h00, 8'h00, 1);
    check("empty_after_rst", pack(0, 1, 8'h00, 8'h00, 9'h000, 3'd0, 8'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/misc_out_fifo.md
MISC_OUT_FIFO -- requirements
Module: misc_out_fifo

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of XOUT1/XOUT2 and OUT_A/OUT_B.
REQ-002 Parameter DEPTH, default 4, SHALL set the FIFO entry count; it SHALL be a power of two, at least 2.
REQ-003 Clocking SHALL be one clock, CLK; reset SHALL be RST, asynchronous and active-high.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 IN_VALID  input  1  upstream XOUT1/XOUT2 pair is valid.
REQ-007 IN_READY  output  1  FIFO can accept a pair.
REQ-008 XOUT1  input  WIDTH  first result from the upstream combinational Misc stage.
REQ-009 XOUT2  input  WIDTH  second result from the upstream combinational Misc stage.
REQ-010 OUT_VALID  output  1  head entry is presented.
REQ-011 OUT_READY  input  1  downstream accepts the head entry.
REQ-012 OUT_A  output  WIDTH  head XOUT1.
REQ-013 OUT_B  output  WIDTH  head XOUT2.
REQ-014 OUT_SUM  output  WIDTH+1  OUT_A + OUT_B, zero-extended, no truncation.
REQ-015 COUNT  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 DROPS  output  8  saturating count of rejected pushes.

Function
REQ-017 A push SHALL occur on a CLK edge where IN_VALID=1 and IN_READY=1; a pop SHALL occur on a CLK edge where OUT_VALID=1 and OUT_READY=1.
REQ-018 IN_READY SHALL equal (COUNT != DEPTH), combinational from registered state only; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-019 OUT_VALID SHALL equal (COUNT != 0); OUT_A, OUT_B and OUT_SUM SHALL reflect the head entry whenever OUT_VALID=1, with no bypass.
REQ-020 Latency SHALL be exactly 1 cycle: a pair pushed into an empty FIFO at edge N SHALL be visible with OUT_VALID=1 after edge N.
REQ-021 Simultaneous push and pop SHALL leave COUNT unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; COUNT SHALL be tracked explicitly so full and empty are unambiguous.
REQ-023 OUT_SUM SHALL be computed combinationally from the stored WIDTH-bit head values; X/Z bits in the inputs SHALL propagate unchanged into storage.
REQ-024 Each edge with IN_VALID=1 and IN_READY=0 SHALL increment DROPS by 1, saturating at 255 with no wrap.
REQ-025 While OUT_VALID=1 and OUT_READY=0, OUT_A, OUT_B and OUT_SUM SHALL remain stable.
REQ-026 When OUT_VALID=0, OUT_A and OUT_B SHALL be 0.

Reset
REQ-027 Asserting RST SHALL immediately, without waiting for CLK, force COUNT=0, both pointers=0, OUT_VALID=0, IN_READY=1, DROPS=0, OUT_A=0, OUT_B=0 and OUT_SUM=0.
REQ-028 A reset asserted mid-operation SHALL discard all stored entries; the first push after RST deasserts SHALL behave as a push into an empty FIFO.
REQ-029 Storage array contents SHALL NOT need a reset; the outputs SHALL be masked per REQ-026.

Structure
REQ-030 The default WIDTH constant and a sum typedef of width WIDTH+1 SHALL live in the shared misc_pkg package.
REQ-031 The pointer, count and drop logic SHALL stay in misc_out_fifo; storage SHALL be the single sub-module misc_fifo_mem, a DEPTH x 2*WIDTH register array with one write port and one asynchronous read port.

Verification
REQ-032 Reset then push (XOUT1=0x10, XOUT2=0x20) -> next cycle OUT_VALID=1, OUT_A=0x10, OUT_B=0x20, OUT_SUM=0x030, COUNT=1.
REQ-033 Push 0xFF/0xFF -> OUT_SUM=0x1FE, with no truncation.
REQ-034 OUT_READY=0, push 5 pairs with DEPTH=4 -> COUNT=4, IN_READY=0, DROPS=1; then pop 4 -> values in push order, COUNT=0.
REQ-035 Full FIFO, IN_VALID=1 and OUT_READY=1 in the same cycle -> one pop, no push, COUNT=3, DROPS incremented by 1.
REQ-036 Hold IN_VALID=1 while full for 300 cycles -> DROPS=255 and stays at 255.
REQ-037 Assert RST between edges with COUNT=3 -> OUT_VALID=0 and COUNT=0 before the next edge; a subsequent push appears after 1 cycle.
